data_ram_wait: RTL and testbench

//  Data-memory responder for the CPU's ram_* port (ce/we/addr/sel/data/data_ready).

---
 rtl/data_ram_wait.sv | 200 ++++++++++++++++++++
 tb/tb_data_ram_wait.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_wait.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_wait
// Brief    : Word-addressed data RAM that answers each access after
//            WAIT_CYCLES wait states, then pulses data_ready for one cycle.
//            Optional macro RAM_ERR_EN enables the out-of-range err flag.
// Revision : 1.0  initial release
// ============================================================================
module data_ram_wait #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        data_ready,
  output logic        err
);

  localparam int         c_depth     = 1 << DEPTH_LOG2;
  localparam logic [7:0] c_wait_init = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [7:0]              r_cnt;
  logic [7:0]              w_next_cnt;
  logic                    w_accept;
  logic                    w_commit;

  logic                    r_we;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [3:0]              r_sel;
  logic [31:0]             r_wdata;

  logic                    w_direct;
  logic                    w_cm_we;
  logic [DEPTH_LOG2-1:0]   w_cm_idx;
  logic [3:0]              w_cm_sel;
  logic [31:0]             w_cm_data;
  logic                    w_cm_oor;
  logic                    w_mem_we;

  logic [31:0]             r_mem [0:c_depth-1];

  // Byte offset bits are the initiator's concern.
  logic                    w_unused_addr_lo;
  assign w_unused_addr_lo = ^addr[1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ce) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_next_state = ST_RESP;
            w_commit     = 1'b1;
          end else begin
            w_next_state = ST_WAIT;
            w_next_cnt   = c_wait_init;
          end
        end
      end
      ST_WAIT: begin
        if (!ce) begin
          w_next_state = ST_IDLE;
        end else if (r_cnt == 8'd0) begin
          w_next_state = ST_RESP;
          w_commit     = 1'b1;
        end else begin
          w_next_cnt = r_cnt - 8'd1;
        end
      end
      ST_RESP: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture; with zero wait states the commit uses the live inputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_sel   <= 4'd0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_we    <= we;
      r_idx   <= addr[DEPTH_LOG2+1:2];
      r_sel   <= sel;
      r_wdata <= data_i;
    end
  end

  assign w_direct  = (r_state == ST_IDLE);
  assign w_cm_we   = w_direct ? we                   : r_we;
  assign w_cm_idx  = w_direct ? addr[DEPTH_LOG2+1:2] : r_idx;
  assign w_cm_sel  = w_direct ? sel                  : r_sel;
  assign w_cm_data = w_direct ? data_i               : r_wdata;

`ifdef RAM_ERR_EN
  logic r_oor;
  logic w_oor;

  assign w_oor = |addr[31:DEPTH_LOG2+2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_oor <= 1'b0;
    end else if (w_accept) begin
      r_oor <= w_oor;
    end
  end

  assign w_cm_oor = w_direct ? w_oor : r_oor;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
      err <= w_commit & w_cm_oor;
    end
  end
`else
  // Upper address bits are ignored: accesses wrap modulo the RAM depth.
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^addr[31:DEPTH_LOG2+2];
  assign w_cm_oor         = 1'b0;
  assign err              = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // RAM array: lane-masked write on the commit edge, never reset
  // ---------------------------------------------------------------------------
  // rst gating keeps a commit from landing on an edge while reset is held.
  assign w_mem_we = w_commit & w_cm_we & ~w_cm_oor & rst;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_cm_sel[i]) begin
          r_mem[w_cm_idx][8*i +: 8] <= w_cm_data[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_ready <= 1'b0;
      data_o     <= 32'd0;
    end else begin
      data_ready <= w_commit;
      if (w_commit) begin
        if (w_cm_oor) begin
          data_o <= 32'd0;
        end else if (!w_cm_we) begin
          data_o <= r_mem[w_cm_idx];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_ram_wait.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_ram_wait
// Brief    : Scoreboard bench for data_ram_wait (WAIT_CYCLES=2 and 0 instances).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_data_ram_wait;

  localparam int DL2  = 10;
  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        ce, we, data_ready, err;
  logic [31:0] addr, data_i, data_o;
  logic [3:0]  sel;

  logic        ce0, we0, data_ready0, err0;
  logic [31:0] addr0, data_i0, data_o0;
  logic [3:0]  sel0;

  data_ram_wait #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WAIT)) u_dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .data_ready(data_ready), .err(err)
  );

  data_ram_wait #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .ce(ce0), .we(we0), .addr(addr0), .sel(sel0),
    .data_i(data_i0), .data_o(data_o0), .data_ready(data_ready0), .err(err0)
  );

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q  [$];
  exp_t        q0 [$];
  logic [31:0] model  [int];
  logic [31:0] model0 [int];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: lane-masked writes, wrap or error on upper address bits.
  function automatic exp_t predict(input bit inst, input bit w, input logic [31:0] a,
                                   input logic [3:0] s, input logic [31:0] d);
    exp_t        e;
    int          idx;
    bit          oor;
    logic [31:0] cur;
    idx = int'(a[DL2+1:2]);
`ifdef RAM_ERR_EN
    oor = |a[31:DL2+2];
`else
    oor = 1'b0;
`endif
    if (inst) cur = model0.exists(idx) ? model0[idx] : 32'h0;
    else      cur = model.exists(idx)  ? model[idx]  : 32'h0;
    e.err      = oor;
    e.chk_data = 1'b1;
    e.data     = 32'h0;
    if (!oor) begin
      if (!w) begin
        e.data = cur;
      end else begin
        e.chk_data = 1'b0;
        for (int i = 0; i < 4; i++)
          if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
        if (inst) model0[idx] = cur;
        else      model[idx]  = cur;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst && data_ready) begin
      if (q.size() == 0) begin
        check("spurious_ready", {31'd0, data_ready}, 32'd0);
      end else begin
        e = q.pop_front();
        check("err", {31'd0, err}, {31'd0, e.err});
        if (e.chk_data) check("data", data_o, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && data_ready0) begin
      if (q0.size() == 0) begin
        check("spurious_ready0", {31'd0, data_ready0}, 32'd0);
      end else begin
        e = q0.pop_front();
        check("err0", {31'd0, err0}, {31'd0, e.err});
        if (e.chk_data) check("data0", data_o0, e.data);
      end
    end
  end

  // One access on the WAIT_CYCLES=2 instance; inputs are scrambled after acceptance.
  task automatic acc(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int lat;
    bit seen;
    @(negedge clk);
    ce = 1'b1; we = w; addr = a; sel = s; data_i = d;
    q.push_back(predict(1'b0, w, a, s, d));
    @(posedge clk);
    #1;
    we = ~w; addr = $urandom; sel = 4'($urandom); data_i = $urandom;
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (data_ready) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    if (seen) check("latency", 32'(lat), 32'(WAIT + 1));
    else      check("timeout", {31'd0, data_ready}, 32'd1);
    ce = 1'b0;
  endtask

  int  last_cyc;
  bit  seen0;
  bit  w0;

  initial begin
    rst = 1'b0;
    ce  = 1'b0; we  = 1'b0; addr  = '0; sel  = '0; data_i  = '0;
    ce0 = 1'b0; we0 = 1'b0; addr0 = '0; sel0 = '0; data_i0 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  {31'd0, data_ready},  32'd0);
    check("rst_data_o", data_o,               32'd0);
    check("rst_err",    {31'd0, err},         32'd0);
    check("rst_ready0", {31'd0, data_ready0}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Full-word write then read back
    acc(1'b1, 32'h10, 4'hF, 32'h12345678);
    acc(1'b0, 32'h10, 4'hF, 32'h0);

    // Byte lanes, including an all-lanes-off write
    acc(1'b1, 32'h20, 4'hF,    32'hAABBCCDD);
    acc(1'b1, 32'h20, 4'b0101, 32'h11223344);
    acc(1'b0, 32'h20, 4'h0,    32'h0);
    acc(1'b1, 32'h22, 4'h0,    32'hFFFFFFFF);
    acc(1'b0, 32'h23, 4'hF,    32'h0);

    // Abort during wait states
    acc(1'b1, 32'h30, 4'hF, 32'h0BADF00D);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = 32'h30; sel = 4'hF; data_i = 32'h55555555;
    @(posedge clk);
    @(negedge clk);
    ce = 1'b0;
    repeat (6) @(negedge clk);
    acc(1'b0, 32'h30, 4'hF, 32'h0);

    // Reset asserted mid-wait of a write
    acc(1'b1, 32'h40, 4'hF, 32'hCAFEBABE);
    acc(1'b0, 32'h40, 4'hF, 32'h0);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = 32'h40; sel = 4'hF; data_i = 32'h01010101;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_data_o", data_o, 32'd0);
    check("midrst_ready",  {31'd0, data_ready}, 32'd0);
    check("midrst_err",    {31'd0, err}, 32'd0);
    ce = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    acc(1'b0, 32'h40, 4'hF, 32'h0);
    acc(1'b1, 32'h44, 4'hF, 32'h600DCAFE);
    acc(1'b0, 32'h44, 4'hF, 32'h0);

    // Address beyond RAM depth
    acc(1'b1, 32'h0,      4'hF, 32'h13579BDF);
    acc(1'b1, 32'h1000,   4'hF, 32'hDEADBEEF);
    acc(1'b0, 32'h0,      4'hF, 32'h0);
    acc(1'b0, 32'h1000,   4'hF, 32'h0);
    acc(1'b0, 32'h803FFC, 4'hF, 32'h0);

    // Zero wait states, ce held high across back-to-back accesses
    @(negedge clk);
    last_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      w0      = (i < 4);
      ce0     = 1'b1;
      we0     = w0;
      addr0   = 32'h100 + 32'(4 * (i % 4));
      sel0    = 4'hF;
      data_i0 = $urandom;
      q0.push_back(predict(1'b1, w0, addr0, sel0, data_i0));
      seen0 = 1'b0;
      for (int n = 0; n < 10 && !seen0; n++) begin
        @(negedge clk);
        if (data_ready0) seen0 = 1'b1;
      end
      if (!seen0) begin
        check("b2b_timeout", {31'd0, data_ready0}, 32'd1);
      end else begin
        if (i > 0) check("b2b_spacing", 32'(cyc - last_cyc), 32'd2);
        last_cyc = cyc;
      end
    end
    ce0 = 1'b0;
    repeat (4) @(negedge clk);

    check("sb_drained",  32'(q.size()),  32'd0);
    check("sb0_drained", 32'(q0.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
